jt51_pg_ring: RTL and testbench

- Parametrised, time-multiplexed phase generator: next generation of the JT51 operator phase path.
- Takes a per-slot base phase step (already octave-shifted by the upstream frequency block), then applies:
  - signed detune with saturation;
  - multiplier;
  - per-slot phase accumulation in a recirculating ring.
- Adds what the fixed 32-slot block lacks: configurable slot count and widths, phase hold, slot-index tracking with sync checking.
- Sits between the keycode/frequency stage and the operator sine lookup.

---
 rtl/jt51_pg_ring.sv | 141 ++++++++++++++
 tb/tb_jt51_pg_ring.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/jt51_pg_ring.sv
// Time-multiplexed phase generator: detune, multiply and per-slot phase accumulation in a ring.
// Optional fixed-step bypass enabled by defining JT51_PG_FIXFREQ_EN.
module jt51_pg_ring #(
   parameter int SLOTS = 32,
   parameter int BASEW = 18,
   parameter int DTW   = 5,
   parameter int PHW   = 20,
   parameter int OUTW  = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cen,
   input  logic                     zero,
   input  logic [BASEW-1:0]         base_I,
   input  logic [DTW-1:0]           dt_I,
   input  logic                     dt_sign_I,
   input  logic [3:0]               mul_I,
   input  logic                     pg_rst_I,
   input  logic                     hold_I,
`ifdef JT51_PG_FIXFREQ_EN
   input  logic                     fix_I,
   input  logic [PHW-1:0]           fix_step_I,
`endif
   output logic [OUTW-1:0]          phase_out,
   output logic [PHW-1:0]           step_out,
   output logic [$clog2(SLOTS)-1:0] slot_out,
   output logic                     sync_err
);

   localparam int SW = $clog2(SLOTS);

   logic [SW-1:0]    cnt, slot_i;
   logic [BASEW:0]   dsum;
   logic [BASEW-1:0] d_i;

   logic [BASEW-1:0] d_ii;
   logic [3:0]       mul_ii;
   logic             rst_ii, hold_ii;
   logic [SW-1:0]    slot_ii;
   logic [BASEW+3:0] prod;
   logic [PHW-1:0]   step_c;

   logic [PHW-1:0]   step_iii;
   logic             rst_iii, hold_iii;
   logic [SW-1:0]    slot_iii;

   logic [PHW-1:0]   acc, acc_next, old;
   logic [PHW-1:0]   step_acc;
   logic [SW-1:0]    slot_acc;
   logic [PHW-1:0]   ring [SLOTS-1];

`ifdef JT51_PG_FIXFREQ_EN
   logic             fix_ii;
   logic [PHW-1:0]   fix_step_ii;
`endif

   // Zero forces the slot index; the counter then predicts the following slot.
   assign slot_i = zero ? '0 : cnt;

   always_comb begin
      dsum = '0;
      d_i  = '0;
      if (dt_sign_I) begin
         dsum = {1'b0, base_I} - (BASEW+1)'(dt_I);
         d_i  = dsum[BASEW] ? '0 : dsum[BASEW-1:0];
      end else begin
         dsum = {1'b0, base_I} + (BASEW+1)'(dt_I);
         d_i  = dsum[BASEW] ? '1 : dsum[BASEW-1:0];
      end
   end

   always_comb begin
      prod = '0;
      if (mul_ii == 4'd0) prod = (BASEW+4)'(d_ii >> 1);
      else                prod = {4'b0, d_ii} * {{BASEW{1'b0}}, mul_ii};
      step_c = PHW'(prod);
`ifdef JT51_PG_FIXFREQ_EN
      if (fix_ii) step_c = fix_step_ii;
`endif
   end

   assign old = ring[SLOTS-2];

   always_comb begin
      acc_next = old + step_iii;
      if (rst_iii)       acc_next = '0;
      else if (hold_iii) acc_next = old;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         sync_err  <= 1'b0;
         d_ii      <= '0;
         mul_ii    <= '0;
         rst_ii    <= 1'b0;
         hold_ii   <= 1'b0;
         slot_ii   <= '0;
         step_iii  <= '0;
         rst_iii   <= 1'b0;
         hold_iii  <= 1'b0;
         slot_iii  <= '0;
         acc       <= '0;
         step_acc  <= '0;
         slot_acc  <= '0;
         phase_out <= '0;
         step_out  <= '0;
         slot_out  <= '0;
         for (int i = 0; i < SLOTS-1; i++) ring[i] <= '0;
`ifdef JT51_PG_FIXFREQ_EN
         fix_ii      <= 1'b0;
         fix_step_ii <= '0;
`endif
      end else if (cen) begin
         cnt      <= (slot_i == SW'(SLOTS-1)) ? '0 : slot_i + SW'(1);
         sync_err <= sync_err | (zero && cnt != '0);
         d_ii     <= d_i;
         mul_ii   <= mul_I;
         rst_ii   <= pg_rst_I;
         hold_ii  <= hold_I;
         slot_ii  <= slot_i;
         step_iii <= step_c;
         rst_iii  <= rst_ii;
         hold_iii <= hold_ii;
         slot_iii <= slot_ii;
         acc      <= acc_next;
         step_acc <= step_iii;
         slot_acc <= slot_iii;
         ring[0]  <= acc;
         for (int i = 1; i < SLOTS-1; i++) ring[i] <= ring[i-1];
         phase_out <= acc[PHW-1 -: OUTW];
         step_out  <= step_acc;
         slot_out  <= slot_acc;
`ifdef JT51_PG_FIXFREQ_EN
         fix_ii      <= fix_I;
         fix_step_ii <= fix_step_I;
`endif
      end
   end

endmodule

// File: tb/tb_jt51_pg_ring.sv
// Bench for jt51_pg_ring: directed frames plus random traffic against a per-slot arithmetic model.
module tb_jt51_pg_ring;

   localparam int SLOTS = 32;
   localparam int BASEW = 18;
   localparam int DTW   = 5;
   localparam int PHW   = 20;
   localparam int OUTW  = 10;
   localparam int SW    = $clog2(SLOTS);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cen = 1'b0;
   logic             zero = 1'b0;
   logic [BASEW-1:0] base_I = '0;
   logic [DTW-1:0]   dt_I = '0;
   logic             dt_sign_I = 1'b0;
   logic [3:0]       mul_I = '0;
   logic             pg_rst_I = 1'b0;
   logic             hold_I = 1'b0;
   logic [OUTW-1:0]  phase_out;
   logic [PHW-1:0]   step_out;
   logic [SW-1:0]    slot_out;
   logic             sync_err;

   jt51_pg_ring dut (
      .clk(clk), .rst(rst), .cen(cen), .zero(zero),
      .base_I(base_I), .dt_I(dt_I), .dt_sign_I(dt_sign_I), .mul_I(mul_I),
      .pg_rst_I(pg_rst_I), .hold_I(hold_I),
      .phase_out(phase_out), .step_out(step_out), .slot_out(slot_out), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   typedef struct { int unsigned ph; int unsigned st; int unsigned sl; } exp_t;

   int          nchk = 0;
   int          nerr = 0;
   int unsigned ph_model [SLOTS];
   int unsigned n_cen;
   int unsigned mcnt;
   int unsigned msync;
   exp_t        q[$];
   exp_t        expv;
   int unsigned ph_seen [SLOTS];
   int unsigned st_seen [SLOTS];

   int unsigned cfg_b  [SLOTS];
   int unsigned cfg_dt [SLOTS];
   int unsigned cfg_sg [SLOTS];
   int unsigned cfg_mu [SLOTS];
   int unsigned cfg_pr [SLOTS];
   int unsigned cfg_hd [SLOTS];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      nchk++;
      assert (got === want) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic mreset();
      foreach (ph_model[i]) ph_model[i] = 0;
      n_cen = 0;
      mcnt  = 0;
      msync = 0;
      q.delete();
      for (int i = 0; i < 3; i++) q.push_back('{0, 0, 0});
      expv = '{0, 0, 0};
   endtask

   task automatic madvance();
      int          d;
      int unsigned st, sl, pos;
      sl = zero ? 0 : mcnt;
      if (zero && mcnt != 0) msync = 1;
      mcnt = (sl + 1) % SLOTS;
      d = int'(base_I) + (dt_sign_I ? -int'(dt_I) : int'(dt_I));
      if (d < 0) d = 0;
      if (d > (1 << BASEW) - 1) d = (1 << BASEW) - 1;
      if (mul_I == 0) st = d / 2;
      else            st = (d * mul_I) % (1 << PHW);
      pos = n_cen % SLOTS;
      if (pg_rst_I)     ph_model[pos] = 0;
      else if (!hold_I) ph_model[pos] = (ph_model[pos] + st) % (1 << PHW);
      n_cen++;
      q.push_back('{ph_model[pos] >> (PHW - OUTW), st, sl});
      expv = q.pop_front();
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) mreset();
      else if (cen) madvance();
      #1;
      chk("phase_out", 32'(phase_out), expv.ph);
      chk("step_out",  32'(step_out),  expv.st);
      chk("slot_out",  32'(slot_out),  expv.sl);
      chk("sync_err",  32'(sync_err),  msync);
      if (cen && !rst) begin
         ph_seen[slot_out] = phase_out;
         st_seen[slot_out] = step_out;
      end
   endtask

   task automatic run_frame();
      for (int s = 0; s < SLOTS; s++) begin
         cen = 1'b1; zero = (s == 0);
         base_I = BASEW'(cfg_b[s]); dt_I = DTW'(cfg_dt[s]); dt_sign_I = cfg_sg[s][0];
         mul_I = 4'(cfg_mu[s]); pg_rst_I = cfg_pr[s][0]; hold_I = cfg_hd[s][0];
         tick();
      end
   endtask

   task automatic set_slot(input int s, input int unsigned b, input int unsigned dt,
                           input int unsigned sg, input int unsigned mu);
      cfg_b[s] = b; cfg_dt[s] = dt; cfg_sg[s] = sg; cfg_mu[s] = mu;
   endtask

   task automatic drive_random();
      cen       = ($urandom_range(0, 3) != 0);
      zero      = (mcnt == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 60) == 0);
      base_I    = BASEW'($urandom);
      dt_I      = DTW'($urandom);
      dt_sign_I = 1'($urandom);
      mul_I     = 4'($urandom);
      pg_rst_I  = ($urandom_range(0, 15) == 0);
      hold_I    = ($urandom_range(0, 7) == 0);
   endtask

   initial begin
      mreset();
      foreach (ph_seen[i]) begin ph_seen[i] = 0; st_seen[i] = 0; end
      for (int s = 0; s < SLOTS; s++) begin
         set_slot(s, $urandom_range(0, (1 << BASEW) - 1), $urandom_range(0, 31),
                  $urandom_range(0, 1), $urandom_range(0, 15));
         cfg_pr[s] = 0; cfg_hd[s] = 0;
      end
      set_slot(0, 1000, 0, 0, 1);
      set_slot(1, 1001, 0, 0, 0);
      set_slot(2, 1000, 0, 0, 15);
      set_slot(3, 10, 20, 1, 1);
      set_slot(4, 1000, 0, 0, 3);
      set_slot(5, 1000, 0, 0, 1);
      set_slot(6, 1000, 0, 0, 1);
      set_slot(8, (1 << BASEW) - 1, 31, 0, 1);
      set_slot(9, 131072, 0, 0, 4);

      rst = 1'b1; cen = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      for (int f = 1; f <= 6; f++) begin
         cfg_pr[5] = (f == 3);
         cfg_hd[5] = (f == 3 || f == 5);
         run_frame();
         if (f == 1) begin
            chk("mul0_step", st_seen[1], 500);
            chk("mul15_step", st_seen[2], 15000);
            chk("dt_floor_step", st_seen[3], 0);
            chk("dt_ceil_step", st_seen[8], (1 << BASEW) - 1);
            chk("wrap_ph_f1", ph_seen[9], 512);
         end
         if (f == 2) begin
            chk("wrap_ph_f2", ph_seen[9], 0);
            chk("slot0_ph_f2", ph_seen[0], 1);
         end
         if (f == 3) begin
            chk("slot0_ph_f3", ph_seen[0], 2);
            chk("slot5_clear", ph_seen[5], 0);
         end
         if (f == 6) begin
            chk("slot5_after_hold", ph_seen[5], 1);
            chk("slot4_ph", ph_seen[4], 17);
            chk("slot6_ph", ph_seen[6], 5);
            chk("dt_floor_frozen", ph_seen[3], 0);
         end
      end

      // zero arriving where the counter expects slot 7
      pg_rst_I = 1'b0; hold_I = 1'b0; cen = 1'b1;
      for (int i = 0; i < 7; i++) begin zero = 1'b0; tick(); end
      zero = 1'b1; tick();
      chk("sync_err_set", 32'(sync_err), 1);
      zero = 1'b0;
      tick(); tick(); tick();
      chk("resync_slot", 32'(slot_out), 0);

      for (int i = 0; i < 400; i++) begin drive_random(); tick(); end

      cen = 1'b0; rst = 1'b1; tick();
      chk("rst_phase", 32'(phase_out), 0);
      chk("rst_sync", 32'(sync_err), 0);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin drive_random(); tick(); end

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule
